// File: rtl/matrix_loader_if.sv
// Stream-in / matrix-out bundle between the element source, the matrix loader
// and the row/column vector feeder that consumes completed matrices.
interface matrix_loader_if #(
  parameter int DIM   = 4,
  parameter int WIDTH = 8
);
  logic                                  s_valid;
  logic                                  s_ready;
  logic [WIDTH-1:0]                      s_data;
  logic                                  s_last;
  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]    mat_out;
  logic                                  mat_valid;
  logic                                  finished;
  logic                                  err_len;

  modport slave (
    input  s_valid, s_data, s_last, finished,
    output s_ready, mat_out, mat_valid, err_len
  );

  modport master (
    output s_valid, s_data, s_last, finished,
    input  s_ready, mat_out, mat_valid, err_len
  );
endinterface

// File: rtl/matrix_loader.sv
// Assembles a row-major element stream into DIM x DIM matrices held in two
// ping-pong banks; the feeder releases one bank at a time via `finished`.
module matrix_loader #(
  parameter int DIM   = 4,
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  matrix_loader_if.slave bus
);
  localparam int              CW       = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(DIM - 1);

  typedef logic [DIM-1:0][DIM-1:0][WIDTH-1:0] matrix_t;

  matrix_t       bank [2];
  logic [1:0]    full;
  logic          wr_sel;
  logic          rd_sel;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic          err_len_q;

  logic accept;
  logic final_beat;
  logic release_bank;

  assign accept       = bus.s_valid && bus.s_ready;
  assign final_beat   = (row == LAST_IDX) && (col == LAST_IDX);
  assign release_bank = bus.finished && full[rd_sel];

  // A full write bank can only be the one being read, so stalling on it also
  // guarantees the displayed matrix is never overwritten.
  assign bus.s_ready   = ~full[wr_sel];
  assign bus.mat_valid = full[rd_sel];
  assign bus.mat_out   = bank[rd_sel];
  assign bus.err_len   = err_len_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank[0]   <= '0;
      bank[1]   <= '0;
      full      <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      row       <= '0;
      col       <= '0;
      err_len_q <= 1'b0;
    end else begin
      err_len_q <= 1'b0;
      if (accept) begin
        bank[wr_sel][row][col] <= bus.s_data;
        if (final_beat) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
          row          <= '0;
          col          <= '0;
          err_len_q    <= ~bus.s_last;
        end else if (bus.s_last) begin
          // Early s_last: restart the same bank, discarding the partial matrix.
          row       <= '0;
          col       <= '0;
          err_len_q <= 1'b1;
        end else if (col == LAST_IDX) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (release_bank) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
    end
  end
endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: table-driven first matrix, then
// scoreboarded sequences for back-pressure, length errors, release and reset.
module tb_matrix_loader;
  typedef logic [3:0][3:0][7:0] mat_t;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       fin;
    logic       exp_ready;
    logic       exp_mvalid;
    logic       exp_err;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  mat_t exp_q[$];

  matrix_loader_if #(.DIM(4), .WIDTH(8)) bus ();

  matrix_loader #(.DIM(4), .WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic last,
                               input logic fin);
    bus.s_valid  = valid;
    bus.s_data   = data;
    bus.s_last   = last;
    bus.finished = fin;
    @(posedge clk);
    #1;
    bus.s_valid  = 1'b0;
    bus.s_last   = 1'b0;
    bus.finished = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] data, input logic last, input logic fin);
    int t = 0;
    while (!bus.s_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.s_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_timeout: s_ready stuck at %0b, required 1", bus.s_ready);
    end
    applyStimulus(1'b1, data, last, fin);
  endtask

  task automatic send_matrix(input string name, input int base, input int nbeats,
                             input bit last_at_end);
    mat_t m = '0;
    bit   saw_err = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      m[i/4][i%4] = 8'(base + i);
      send_beat(8'(base + i), (i == nbeats - 1) && last_at_end, 1'b0);
      if (i != nbeats - 1 && bus.err_len) saw_err = 1'b1;
    end
    if (nbeats == 16) exp_q.push_back(m);
    checkOutput({name, "_err_mid"}, 128'(saw_err), 128'(0));
    checkOutput({name, "_err_end"}, 128'(bus.err_len), 128'(nbeats != 16 || !last_at_end));
  endtask

  task automatic drain_one(input string name);
    int   t = 0;
    mat_t exp_m;
    while (!bus.mat_valid && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.mat_valid || exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_drain: mat_valid=%0b queued=%0d, required 1 and >0",
               name, bus.mat_valid, exp_q.size());
    end else begin
      exp_m = exp_q.pop_front();
      checkOutput({name, "_mat_out"}, bus.mat_out, exp_m);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t vecs[16];
    mat_t m;
    mat_t tmp;

    for (int i = 0; i < 16; i++)
      vecs[i] = '{valid: 1'b1, data: 8'(i + 1), last: (i == 15), fin: 1'b0,
                  exp_ready: 1'b1, exp_mvalid: (i == 15), exp_err: 1'b0};

    reset_n      = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.s_last   = 1'b0;
    bus.finished = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 128'(bus.s_ready), 128'(1));
    checkOutput("rst_mvalid", 128'(bus.mat_valid), 128'(0));
    checkOutput("rst_mat_out", bus.mat_out, 128'(0));
    checkOutput("rst_err", 128'(bus.err_len), 128'(0));
    reset_n = 1'b1;

    // Test 1: first matrix 1..16 from the vector table
    m = '0;
    for (int i = 0; i < 16; i++) begin
      m[i/4][i%4] = vecs[i].data;
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].fin);
      if (vecs[i].last) exp_q.push_back(m);
      checkOutput($sformatf("t1_ready_%0d", i), 128'(bus.s_ready), 128'(vecs[i].exp_ready));
      checkOutput($sformatf("t1_mvalid_%0d", i), 128'(bus.mat_valid), 128'(vecs[i].exp_mvalid));
      checkOutput($sformatf("t1_err_%0d", i), 128'(bus.err_len), 128'(vecs[i].exp_err));
    end
    checkOutput("t1_m00", 128'(bus.mat_out[0][0]), 128'(1));
    checkOutput("t1_m03", 128'(bus.mat_out[0][3]), 128'(4));
    checkOutput("t1_m33", 128'(bus.mat_out[3][3]), 128'(16));

    // Test 2: second matrix fills the other bank, loader stalls
    send_matrix("t2", 17, 16, 1'b1);
    checkOutput("t2_ready_stall", 128'(bus.s_ready), 128'(0));
    checkOutput("t2_mvalid", 128'(bus.mat_valid), 128'(1));
    drain_one("t2_first");
    checkOutput("t2_ready_after", 128'(bus.s_ready), 128'(1));
    checkOutput("t2_mvalid_after", 128'(bus.mat_valid), 128'(1));
    if (exp_q.size() > 0) checkOutput("t2_second_shown", bus.mat_out, exp_q[0]);
    drain_one("t2_second");
    checkOutput("t2_empty", 128'(bus.mat_valid), 128'(0));

    // Test 3: early s_last aborts, following matrix is clean
    send_matrix("t3_short", 200, 5, 1'b1);
    checkOutput("t3_mvalid_short", 128'(bus.mat_valid), 128'(0));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t3_err_pulse_end", 128'(bus.err_len), 128'(0));
    send_matrix("t3_full", 100, 16, 1'b1);
    checkOutput("t3_m00", 128'(bus.mat_out[0][0]), 128'(100));
    drain_one("t3");

    // Test 4: missing s_last still commits but flags an error
    send_matrix("t4", 50, 16, 1'b0);
    checkOutput("t4_mvalid", 128'(bus.mat_valid), 128'(1));
    drain_one("t4");

    // Test 5: stray finished ignored; finished coinciding with a final beat
    checkOutput("t5_idle_mvalid", 128'(bus.mat_valid), 128'(0));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t5_stray_mvalid", 128'(bus.mat_valid), 128'(0));
    checkOutput("t5_stray_ready", 128'(bus.s_ready), 128'(1));
    send_matrix("t5_a", 60, 16, 1'b1);
    m = '0;
    for (int i = 0; i < 15; i++) begin
      m[i/4][i%4] = 8'(80 + i);
      send_beat(8'(80 + i), 1'b0, 1'b0);
    end
    checkOutput("t5_a_mvalid", 128'(bus.mat_valid), 128'(1));
    if (exp_q.size() > 0) begin
      tmp = exp_q.pop_front();
      checkOutput("t5_a_shown", bus.mat_out, tmp);
    end
    checkOutput("t5_ready_pre", 128'(bus.s_ready), 128'(1));
    m[3][3] = 8'd95;
    applyStimulus(1'b1, 8'd95, 1'b1, 1'b1);
    exp_q.push_back(m);
    checkOutput("t5_b_mvalid", 128'(bus.mat_valid), 128'(1));
    checkOutput("t5_b_ready", 128'(bus.s_ready), 128'(1));
    checkOutput("t5_b_err", 128'(bus.err_len), 128'(0));
    drain_one("t5_b");

    // Test 6: asynchronous reset with one full bank and a partial one
    send_matrix("t6_pre", 70, 16, 1'b1);
    for (int i = 0; i < 8; i++) send_beat(8'(i + 1), 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("t6_rst_ready", 128'(bus.s_ready), 128'(1));
    checkOutput("t6_rst_mvalid", 128'(bus.mat_valid), 128'(0));
    checkOutput("t6_rst_mat_out", bus.mat_out, 128'(0));
    checkOutput("t6_rst_err", 128'(bus.err_len), 128'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_matrix("t6_post", 150, 16, 1'b1);
    drain_one("t6");
    checkOutput("t6_mvalid_end", 128'(bus.mat_valid), 128'(0));
    checkOutput("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
